// File: rtl/window_buffer.sv
// KxK sliding-window generator for the streaming pixel pipeline.
// K-1 line delays feed a KxK register window; one window is emitted per
// accepted pixel together with its raster coordinates and a validity flag
// that is only raised once the window lies fully inside the current frame.
module window_buffer #(
  parameter int DATA_WIDTH = 12,
  parameter int LINE_WIDTH = 640,
  parameter int K          = 3,
  parameter int COL_BITS   = 10,
  parameter int ROW_BITS   = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        pixel_in,
  input  logic                         pixel_valid,
  input  logic                         frame_start,
  output logic [K*K*DATA_WIDTH-1:0]    window_out,
  output logic                         window_valid,
  output logic [COL_BITS-1:0]          window_col,
  output logic [ROW_BITS-1:0]          window_row
);

  // K entries of every row live in the window registers, so each line delay
  // only has to cover the remainder of the line.
  localparam int DLY = LINE_WIDTH - K;

  logic [DATA_WIDTH-1:0] win     [K][K];
  logic [DATA_WIDTH-1:0] dly_out [K-1];

  logic [COL_BITS-1:0] col_cnt;
  logic [ROW_BITS-1:0] row_cnt;
  logic [COL_BITS-1:0] cur_col;
  logic [ROW_BITS-1:0] cur_row;

  // Coordinates of the pixel being accepted; frame_start forces it to origin.
  always_comb begin
    cur_col = frame_start ? '0 : col_cnt;
    cur_row = frame_start ? '0 : row_cnt;
  end

  generate
    if (DLY == 0) begin : g_nodly
      for (genvar r = 0; r < K-1; r++) begin : g_tap
        assign dly_out[r] = win[r+1][0];
      end
    end else begin : g_dly
      localparam int PTR_W = (DLY > 1) ? $clog2(DLY) : 1;

      logic [DATA_WIDTH-1:0] mem [K-1][DLY];
      logic [PTR_W-1:0]      ptr;

      // Shared circular pointer: the slot read this accept was written DLY accepts ago.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          ptr <= '0;
        end else if (pixel_valid) begin
          if (ptr == PTR_W'(DLY-1)) ptr <= '0;
          else                      ptr <= ptr + 1'b1;
        end
      end

      // Line storage is deliberately not reset so it can map onto block RAM.
      always_ff @(posedge clk) begin
        if (pixel_valid) begin
          for (int r = 0; r < K-1; r++) mem[r][ptr] <= win[r+1][0];
        end
      end

      for (genvar r = 0; r < K-1; r++) begin : g_tap
        assign dly_out[r] = mem[r][ptr];
      end
    end
  endgenerate

  // Window registers: every row shifts left; row K-1 takes the new pixel,
  // the upper rows take the output of their line delay.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          win[r][c] <= '0;
    end else if (pixel_valid) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K-1; c++)
          win[r][c] <= win[r][c+1];
      for (int r = 0; r < K-1; r++)
        win[r][K-1] <= dly_out[r];
      win[K-1][K-1] <= pixel_in;
    end
  end

  // Flatten the window, element (r,c) at index r*K+c.
  always_comb begin
    window_out = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        window_out[(r*K+c)*DATA_WIDTH +: DATA_WIDTH] = win[r][c];
  end

  // Raster counters and the registered coordinate / validity outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_cnt      <= '0;
      row_cnt      <= '0;
      window_col   <= '0;
      window_row   <= '0;
      window_valid <= 1'b0;
    end else if (pixel_valid) begin
      window_col   <= cur_col;
      window_row   <= cur_row;
      window_valid <= (cur_row >= ROW_BITS'(K-1)) && (cur_col >= COL_BITS'(K-1));
      if (cur_col == COL_BITS'(LINE_WIDTH-1)) begin
        col_cnt <= '0;
        if (cur_row != '1) row_cnt <= cur_row + 1'b1;
        else               row_cnt <= cur_row;
      end else begin
        col_cnt <= cur_col + 1'b1;
        row_cnt <= cur_row;
      end
    end else begin
      window_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_window_buffer.sv
// Directed bench for window_buffer: a K=3/LINE_WIDTH=8 instance and a
// K=5/LINE_WIDTH=16 instance, checked against a raster-coordinate model.
module tb_window_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [11:0]  a_pix;
  logic         a_pv, a_fs;
  logic [107:0] a_win;
  logic         a_wv;
  logic [9:0]   a_col, a_row;

  logic [11:0]  b_pix;
  logic         b_pv, b_fs;
  logic [299:0] b_win;
  logic         b_wv;
  logic [9:0]   b_col, b_row;

  window_buffer #(.DATA_WIDTH(12), .LINE_WIDTH(8), .K(3), .COL_BITS(10), .ROW_BITS(10)) dut_a (
    .clk(clk), .rst(rst), .pixel_in(a_pix), .pixel_valid(a_pv), .frame_start(a_fs),
    .window_out(a_win), .window_valid(a_wv), .window_col(a_col), .window_row(a_row));

  window_buffer #(.DATA_WIDTH(12), .LINE_WIDTH(16), .K(5), .COL_BITS(10), .ROW_BITS(10)) dut_b (
    .clk(clk), .rst(rst), .pixel_in(b_pix), .pixel_valid(b_pv), .frame_start(b_fs),
    .window_out(b_win), .window_valid(b_wv), .window_col(b_col), .window_row(b_row));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [11:0] pix;
    logic        fs;
    logic        exp_v;
    logic [9:0]  exp_col;
    logic [9:0]  exp_row;
  } vec_t;

  vec_t tbl[40];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_win(input string name, input logic [299:0] act, input logic [299:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] pv(input int tag, input int row, input int col);
    return 12'((tag << 11) | ((row & 127) << 4) | (col & 15));
  endfunction

  function automatic logic [299:0] model_win(input int k, input int tag, input int row, input int col);
    logic [299:0] w;
    w = '0;
    for (int r = 0; r < k; r++)
      for (int c = 0; c < k; c++)
        w[(r*k+c)*12 +: 12] = pv(tag, row-(k-1-r), col-(k-1-c));
    return w;
  endfunction

  task automatic a_accept(input logic [11:0] pix, input logic fs);
    @(negedge clk);
    a_pix = pix; a_fs = fs; a_pv = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic a_idle(input logic fs);
    @(negedge clk);
    a_pv = 1'b0; a_fs = fs;
    @(posedge clk); #1;
  endtask

  task automatic b_accept(input logic [11:0] pix, input logic fs);
    @(negedge clk);
    b_pix = pix; b_fs = fs; b_pv = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic a_check(input string tag, input int ftag, input logic ev, input int row, input int col);
    chk($sformatf("%s_valid r%0d c%0d", tag, row, col), 32'(a_wv), 32'(ev));
    chk($sformatf("%s_col r%0d c%0d", tag, row, col), 32'(a_col), 32'(col));
    chk($sformatf("%s_row r%0d c%0d", tag, row, col), 32'(a_row), 32'(row));
    if (ev)
      chk_win($sformatf("%s_window r%0d c%0d", tag, row, col), 300'(a_win), model_win(3, ftag, row, col));
  endtask

  initial begin
    rst = 1'b0;
    a_pix = '0; a_pv = 1'b0; a_fs = 1'b0;
    b_pix = '0; b_pv = 1'b0; b_fs = 1'b0;

    for (int i = 0; i < 40; i++) begin
      tbl[i].pix     = pv(0, i/8, i%8);
      tbl[i].fs      = (i == 0);
      tbl[i].exp_v   = ((i/8) >= 2) && ((i%8) >= 2);
      tbl[i].exp_col = 10'(i%8);
      tbl[i].exp_row = 10'(i/8);
    end

    // Reset state
    #12;
    chk("reset_valid", 32'(a_wv), 32'd0);
    chk("reset_col", 32'(a_col), 32'd0);
    chk("reset_row", 32'(a_row), 32'd0);
    chk_win("reset_window", 300'(a_win), 300'd0);
    @(negedge clk);
    rst = 1'b1;

    // Fill and line wrap, gap-free
    for (int i = 0; i < 40; i++) begin
      a_accept(tbl[i].pix, tbl[i].fs);
      a_check("fill", 0, tbl[i].exp_v, int'(tbl[i].exp_row), int'(tbl[i].exp_col));
      if (i == 18)
        chk_win("first_window", 300'(a_win),
                300'({12'h022, 12'h021, 12'h020, 12'h012, 12'h011, 12'h010, 12'h002, 12'h001, 12'h000}));
      if (i == 26)
        chk_win("wrap_window", 300'(a_win),
                300'({12'h032, 12'h031, 12'h030, 12'h022, 12'h021, 12'h020, 12'h012, 12'h011, 12'h010}));
    end

    // Same stream with random idle gaps
    for (int i = 0; i < 40; i++) begin
      int gap;
      a_accept(tbl[i].pix, tbl[i].fs);
      a_check("stall", 0, tbl[i].exp_v, int'(tbl[i].exp_row), int'(tbl[i].exp_col));
      gap = int'($urandom_range(0, 5));
      for (int g = 0; g < gap; g++) begin
        a_idle(1'b0);
        chk($sformatf("stall_idle_valid i%0d", i), 32'(a_wv), 32'd0);
      end
    end

    // Frame A up to row 5 col 3, then frame B starts at what would be row 5 col 4
    for (int i = 0; i < 44; i++) a_accept(pv(0, i/8, i%8), i == 0);
    chk("frameA_row", 32'(a_row), 32'd5);
    chk("frameA_col", 32'(a_col), 32'd3);
    for (int j = 0; j < 36; j++) begin
      if (j == 10) begin
        a_idle(1'b1);
        chk("idle_fs_valid", 32'(a_wv), 32'd0);
      end
      a_accept(pv(1, j/8, j%8), j == 0);
      a_check("frameB", 1, ((j/8) >= 2) && ((j%8) >= 2), j/8, j%8);
    end

    // Asynchronous reset mid-stream (last window above was valid)
    #2;
    rst = 1'b0;
    a_pv = 1'b0;
    #1;
    chk("midrst_valid", 32'(a_wv), 32'd0);
    chk("midrst_col", 32'(a_col), 32'd0);
    chk("midrst_row", 32'(a_row), 32'd0);
    chk_win("midrst_window", 300'(a_win), 300'd0);
    @(negedge clk);
    rst = 1'b1;
    a_accept(12'h055, 1'b0);
    chk("postrst_col0", 32'(a_col), 32'd0);
    chk("postrst_row0", 32'(a_row), 32'd0);
    chk("postrst_valid0", 32'(a_wv), 32'd0);
    a_accept(12'h056, 1'b0);
    chk("postrst_col1", 32'(a_col), 32'd1);
    chk("postrst_row1", 32'(a_row), 32'd0);

    // Row counter saturation
    for (int n = 0; n < 1026*8; n++) begin
      a_accept(12'(n), n == 0);
      if (n == 1023*8 + 7) begin
        chk("sat_row_last", 32'(a_row), 32'd1023);
        chk("sat_col_last", 32'(a_col), 32'd7);
      end
      if (n == 1024*8) begin
        chk("sat_row_hold", 32'(a_row), 32'd1023);
        chk("sat_col_wrap", 32'(a_col), 32'd0);
        chk("sat_valid_col0", 32'(a_wv), 32'd0);
      end
      if (n == 1025*8 + 2) begin
        chk("sat_row_hold2", 32'(a_row), 32'd1023);
        chk("sat_valid_col2", 32'(a_wv), 32'd1);
      end
    end
    @(negedge clk);
    a_pv = 1'b0;

    // Generic K=5, LINE_WIDTH=16
    for (int i = 0; i < 96; i++) begin
      int r, c;
      logic ev;
      r = i / 16;
      c = i % 16;
      ev = (r >= 4) && (c >= 4);
      b_accept(pv(0, r, c), i == 0);
      chk($sformatf("k5_valid r%0d c%0d", r, c), 32'(b_wv), 32'(ev));
      chk($sformatf("k5_col r%0d c%0d", r, c), 32'(b_col), 32'(c));
      chk($sformatf("k5_row r%0d c%0d", r, c), 32'(b_row), 32'(r));
      if (ev)
        chk_win($sformatf("k5_window r%0d c%0d", r, c), b_win, model_win(5, 0, r, c));
    end
    @(negedge clk);
    b_pv = 1'b0;
    @(posedge clk); #1;
    chk("k5_idle_valid", 32'(b_wv), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/window_buffer.md
Name: window_buffer

Overview:
Parametrised KxK sliding-window generator for the streaming 12-bit pixel pipeline. It is the successor to the 3-row line buffer and feeds the convolution and edge-detection stages. It holds K-1 line delays plus a KxK register window and emits a full window per accepted pixel, with validity gating and raster coordinates. It generalises line width, kernel size and frame handling, adding frame-start resynchronisation and border-aware valid generation.

Parameters:
DATA_WIDTH, 12, bits per pixel
LINE_WIDTH, 640, pixels per line (>= K)
K, 3, window height and width (odd, 3..7)
COL_BITS, 10, width of column coordinate (2^COL_BITS >= LINE_WIDTH)
ROW_BITS, 10, width of row coordinate

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
pixel_in  in  DATA_WIDTH  raster-order pixel
pixel_valid  in  1  pixel_in accepted this cycle
frame_start  in  1  qualifies the first pixel of a frame; sampled only with pixel_valid
window_out  out  K*K*DATA_WIDTH  window; element (r,c) at bits [(r*K+c)*DATA_WIDTH +: DATA_WIDTH]
window_valid  out  1  window_out complete and inside frame
window_col  out  COL_BITS  column of the newest pixel (element K-1,K-1)
window_row  out  ROW_BITS  row of the newest pixel

Behaviour:
- Reset: rst is asynchronous and active-low; clock is clk. Reset clears window registers, window_out, window_valid, window_col, window_row and the counters to 0. Line-delay storage is not reset; it may map to block RAM, and stale contents are masked by valid gating.
- Accept: every state element advances only on a cycle with pixel_valid=1. With pixel_valid=0 everything holds, except window_valid, which is 0 the next cycle (one pulse per accepted pixel).
- Window geometry: r=0 is the oldest row (top) and c=0 the oldest column (left). Element (K-1,K-1) is the pixel just accepted. Row r of the window is the output of a line-delay chain tapped (K-1-r)*LINE_WIDTH accepted pixels earlier. Each row shifts left by one column per accept.
- Latency: a pixel accepted in cycle n appears at element (K-1,K-1) with window_valid, window_col and window_row updated at n+1. All outputs are registered.
- Counters: col counts 0..LINE_WIDTH-1 and wraps to 0. On wrap, row increments and saturates at 2^ROW_BITS-1. window_col and window_row report the counters as they were for the accepted pixel.
- Valid rule: window_valid=1 at n+1 iff the pixel at n was accepted, its row >= K-1 and its col >= K-1. This masks windows that straddle a line wrap or precede full line fill. There is no padding; edge pixels yield no window.
- Frame start: pixel_valid=1 with frame_start=1 forces that pixel to col=0, row=0 regardless of count. It is written into the datapath normally and line storage is not flushed. Validity restarts: the first valid window is the pixel at row K-1, col K-1 of the new frame.
- frame_start with pixel_valid=0 is ignored.
- A frame shorter than K-1 rows never produces window_valid.
- Reset mid-stream: outputs drop to 0 immediately (asynchronous). After release, behaviour is that of power-up; the first accepted pixel is row 0, col 0 even without frame_start.
- Implementation: K-1 line delays of LINE_WIDTH-K entries each, since K entries per row sit in window registers, or an equivalent circular RAM with a shared write/read pointer. Target size is 120-400 lines of RTL.

Test Plan:
- Reset: K=3, LINE_WIDTH=8, hold rst=0 mid-stream -> window_out=0, window_valid=0, window_col=0 and window_row=0 asynchronously; after release the first pixel reports row 0, col 0.
- Fill: stream pixel=(row<<4)|col with continuous pixel_valid -> the first window_valid pulse is at row 2, col 2. Element order (0,0)..(2,2) = 0x00,01,02,10,11,12,20,21,22, appearing the cycle after pixel 0x22.
- Line wrap: continue into row 3 -> window_valid=0 at cols 0 and 1; col 2 gives 0x10,11,12,20,21,22,30,31,32; col 7 then row 4 col 2 are both valid.
- Stall: same stream with random pixel_valid gaps of 0..5 cycles -> the sequence of valid windows and coordinates is identical to the gap-free run, and window_valid never stays high across an idle cycle.
- Frame start: assert frame_start at row 5, col 4 of frame A -> coordinates restart at 0,0. No window_valid until new-frame row 2, col 2, whose window holds only new-frame pixels.
- Generic: K=5, LINE_WIDTH=16 -> the first valid window is at row 4, col 4, with 25 elements matching the raster model; window_valid=0 for col<4 on every row.
